// File: rtl/banco_registri_pkg.sv
// Shared defaults and helpers for the banco_registri register file.
package banco_registri_pkg;

  localparam int N_DEFAULT    = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int ZERO_ADDR    = 0;

  function automatic int addr_width(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/banco_registri_registro_p.sv
// N-bit data register with write enable and synchronous active-high reset.
module registro_p #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/banco_registri.sv
// Register file: 2 async read ports, 1 sync write port, per-register pending bits.
// Optional same-cycle write-to-read bypass under BANCO_REGISTRI_BYPASS_EN.
module banco_registri
  import banco_registri_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = addr_width(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  out1,
  output logic [N-1:0]  out2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  in,
  input  logic          res,
  input  logic [AW-1:0] rd,
  output logic [AW:0]   npend
);

  // we and res are plain per-cycle qualifiers: no valid/ready, every asserted
  // cycle is consumed at the next rising edge.
  logic [N-1:0]    regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic [AW:0]     npend_next;
  logic            do_write;
  logic            do_res;
  logic            set_p;
  logic            clr_p;

  assign do_write = we  && (wa != AW'(ZERO_ADDR));
  assign do_res   = res && (rd != AW'(ZERO_ADDR));

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_entry
      logic en;
      assign en = we && (wa == AW'(i));
      registro_p #(.N(N)) u_reg (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .d     (in),
        .q     (regs[i])
      );
    end
  end

  // Reserve is applied after release so a same-register pair ends pending.
  always_comb begin
    pend_next = pend;
    if (do_write) pend_next[wa] = 1'b0;
    if (do_res)   pend_next[rd] = 1'b1;
    set_p = do_res && !pend[rd];
    clr_p = do_write && pend[wa] && !(do_res && (rd == wa));
    npend_next = npend;
    if (set_p && !clr_p) begin
      npend_next = npend + 1'b1;
    end else if (clr_p && !set_p) begin
      npend_next = npend - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend  <= '0;
      npend <= '0;
    end else begin
      pend  <= pend_next;
      npend <= npend_next;
    end
  end

  always_comb begin
    out1  = regs[ra1];
    busy1 = pend[ra1];
    out2  = regs[ra2];
    busy2 = pend[ra2];
`ifdef BANCO_REGISTRI_BYPASS_EN
    if (do_write && (wa == ra1)) begin
      out1  = in;
      busy1 = 1'b0;
    end
    if (do_write && (wa == ra2)) begin
      out2  = in;
      busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_banco_registri.sv
// Self-checking bench for banco_registri (default N=32, NREG=32).
module tb_banco_registri;

  localparam int N    = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0, rd = '0;
  logic          we = 1'b0, res = 1'b0;
  logic [N-1:0]  in_d = '0;
  logic [N-1:0]  out1, out2;
  logic          busy1, busy2;
  logic [AW:0]   npend;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_v;

  logic [N-1:0] mdl_r [NREG];
  logic         mdl_p [NREG];

  banco_registri dut (
    .clock (clock),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .out1  (out1),
    .out2  (out2),
    .busy1 (busy1),
    .busy2 (busy2),
    .we    (we),
    .wa    (wa),
    .in    (in_d),
    .res   (res),
    .rd    (rd),
    .npend (npend)
  );

  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic op(input logic w, input logic [AW-1:0] a, input logic [N-1:0] d,
                    input logic r, input logic [AW-1:0] ra);
    we = w; wa = a; in_d = d; res = r; rd = ra;
    @(posedge clock); #1;
    we = 1'b0; res = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra1 = a1; ra2 = a2; #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      read(AW'(a), AW'(NREG - 1 - a));
      total++;
      if (out1 !== '0 || out2 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        bad++;
        $display("FAIL reset_read a=%0d got out1=%h out2=%h busy1=%b busy2=%b want all 0",
                 a, out1, out2, busy1, busy2);
      end
    end
    total++;
    if (npend !== '0) begin
      bad++;
      $display("FAIL reset_npend got %0d want 0", npend);
    end
  endtask

  task automatic test_write();
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    op(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0);
    read(5'd5, 5'd5);
    exp_v = exp_q.pop_front();
    total++;
    if (out1 !== exp_v) begin
      bad++; $display("FAIL write_r5_p1 got %h want %h", out1, exp_v);
    end
    exp_v = exp_q.pop_front();
    total++;
    if (out2 !== exp_v) begin
      bad++; $display("FAIL write_r5_p2 got %h want %h", out2, exp_v);
    end
    exp_q.push_back(32'h0);
    op(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    read(5'd0, 5'd0);
    exp_v = exp_q.pop_front();
    total++;
    if (out1 !== exp_v || out2 !== exp_v || busy1 !== 1'b0 || npend !== '0) begin
      bad++;
      $display("FAIL write_r0 got out1=%h out2=%h busy1=%b npend=%0d want %h/%h/0/0",
               out1, out2, busy1, npend, exp_v, exp_v);
    end
  endtask

  task automatic test_pending();
    op(1'b0, '0, '0, 1'b1, 5'd3);
    read(5'd3, 5'd3);
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || npend !== 6'd1) begin
      bad++;
      $display("FAIL reserve_r3 got busy=%b%b npend=%0d want 11 1", busy1, busy2, npend);
    end
    exp_q.push_back(32'h55);
    op(1'b1, 5'd3, 32'h55, 1'b0, '0);
    read(5'd3, 5'd3);
    exp_v = exp_q.pop_front();
    total++;
    if (out1 !== exp_v || busy1 !== 1'b0 || npend !== 6'd0) begin
      bad++;
      $display("FAIL release_r3 got out=%h busy=%b npend=%0d want %h 0 0", out1, busy1, npend, exp_v);
    end
  endtask

  task automatic test_same_cycle();
    exp_q.push_back(32'hA5);
    op(1'b1, 5'd7, 32'hA5, 1'b1, 5'd7);
    read(5'd7, 5'd7);
    exp_v = exp_q.pop_front();
    total++;
    if (out1 !== exp_v || busy1 !== 1'b1 || npend !== 6'd1) begin
      bad++;
      $display("FAIL wr_res_r7 got out=%h busy=%b npend=%0d want %h 1 1", out1, busy1, npend, exp_v);
    end
    op(1'b0, '0, '0, 1'b1, 5'd2);
    total++;
    if (npend !== 6'd2) begin
      bad++; $display("FAIL reserve_r2 got npend=%0d want 2", npend);
    end
    op(1'b0, '0, '0, 1'b1, 5'd2);
    total++;
    if (npend !== 6'd2) begin
      bad++; $display("FAIL rereserve_r2 got npend=%0d want 2", npend);
    end
    op(1'b1, 5'd2, 32'h22, 1'b1, 5'd4);
    read(5'd2, 5'd4);
    total++;
    if (npend !== 6'd2 || busy1 !== 1'b0 || busy2 !== 1'b1 || out1 !== 32'h22) begin
      bad++;
      $display("FAIL res4_rel2 got npend=%0d busy2r=%b busy4r=%b out=%h want 2 0 1 00000022",
               npend, busy1, busy2, out1);
    end
    op(1'b1, 5'd9, 32'h99, 1'b0, '0);
    read(5'd9, 5'd9);
    total++;
    if (npend !== 6'd2 || busy1 !== 1'b0 || out1 !== 32'h99) begin
      bad++;
      $display("FAIL write_nonpending got npend=%0d busy=%b out=%h want 2 0 00000099", npend, busy1, out1);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd9; in_d = 32'h77; ra1 = 5'd9; ra2 = 5'd9; #1;
`ifdef BANCO_REGISTRI_BYPASS_EN
    exp_v = 32'h77;
`else
    exp_v = 32'h99;
`endif
    total++;
    if (out1 !== exp_v || out2 !== exp_v || busy1 !== 1'b0) begin
      bad++; $display("FAIL bypass_same got out1=%h out2=%h busy=%b want %h 0", out1, out2, busy1, exp_v);
    end
    @(posedge clock); #1;
    we = 1'b0; #1;
    total++;
    if (out1 !== 32'h77) begin
      bad++; $display("FAIL bypass_next got %h want 00000077", out1);
    end
  endtask

  task automatic test_back_to_back();
    logic          w, r, p_new [NREG];
    logic [AW-1:0] a, b, ra;
    logic [N-1:0]  d, e_out;
    logic          e_busy;
    int            cnt;
    do_reset();
    for (int i = 0; i < NREG; i++) begin
      mdl_r[i] = '0; mdl_p[i] = 1'b0;
    end
    for (int it = 0; it < 60; it++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 7));
      b  = AW'($urandom_range(0, 7));
      ra = AW'($urandom_range(0, 7));
      d  = $urandom;
      we = w; wa = a; in_d = d; res = r; rd = b; ra1 = ra; #1;
      e_out = mdl_r[ra]; e_busy = mdl_p[ra];
`ifdef BANCO_REGISTRI_BYPASS_EN
      if (w && a != 0 && a == ra) begin
        e_out = d; e_busy = 1'b0;
      end
`endif
      total++;
      if (out1 !== e_out || busy1 !== e_busy) begin
        bad++;
        $display("FAIL b2b_read it=%0d ra=%0d got %h/%b want %h/%b", it, ra, out1, busy1, e_out, e_busy);
      end
      p_new = mdl_p;
      if (w && a != 0) begin
        mdl_r[a] = d; p_new[a] = 1'b0;
      end
      if (r && b != 0) p_new[b] = 1'b1;
      mdl_p = p_new;
      cnt = 0;
      for (int i = 0; i < NREG; i++) cnt += int'(mdl_p[i]);
      exp_q.push_back(N'(cnt));
      @(posedge clock); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({26'd0, npend} !== exp_v) begin
        bad++; $display("FAIL b2b_npend it=%0d got %0d want %0d", it, npend, exp_v);
      end
    end
    we = 1'b0; res = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 4; i++) op(1'b0, '0, '0, 1'b1, AW'(i));
    total++;
    if (npend !== 6'd4) begin
      bad++; $display("FAIL reserve_1to4 got npend=%0d want 4", npend);
    end
    we = 1'b1; wa = 5'd2; in_d = 32'hFF; res = 1'b1; rd = 5'd6; reset = 1'b1;
    @(posedge clock); #1;
    we = 1'b0; res = 1'b0; reset = 1'b0;
    total++;
    if (npend !== '0) begin
      bad++; $display("FAIL midreset_npend got %0d want 0", npend);
    end
    for (int a = 0; a < NREG; a++) begin
      read(AW'(a), AW'(a));
      total++;
      if (out1 !== '0 || out2 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        bad++;
        $display("FAIL midreset_read a=%0d got %h/%h busy %b%b want 0", a, out1, out2, busy1, busy2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_pending();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
